// File: rtl/adder_operand_packer.sv
// Packs a serial stream of signed products into one NUM_INPUTS-word window for the
// pipelined adder tree, zero-pads short windows and tracks windows awaiting results.
module adder_operand_packer #(
  parameter int bitsize     = 14,
  parameter int NUM_INPUTS  = 27,
  parameter int MAX_PENDING = 8,
  parameter int PEND_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [bitsize-1:0]            in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic [NUM_INPUTS*bitsize-1:0] input_numbers,
  output logic                          start_adder,
  input  logic                          adder_valid,
  output logic [PEND_W-1:0]             pending,
  output logic                          idle,
  output logic                          short_window,
  output logic                          overflow_err
);

  localparam int CNT_W = $clog2(NUM_INPUTS);
  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(NUM_INPUTS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [bitsize-1:0] slot_q [NUM_INPUTS];
  logic [bitsize-1:0] slot_d [NUM_INPUTS];
  logic               start_q, start_d;
  logic               short_q, short_d;
  logic               ovf_q, ovf_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               accept_s;
  logic               close_s;

  assign in_ready = (pend_q < PEND_MAX);
  assign accept_s = in_valid & in_ready;
  assign close_s  = accept_s & (in_last | (cnt_q == LAST_SLOT));

  // Next-state: slot writes with zero-fill above the closing slot, and pending bookkeeping
  always_comb begin
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    start_d = 1'b0;
    short_d = 1'b0;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    if (accept_s) begin
      slot_d[cnt_q] = in_data;
      if (close_s) begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          slot_d[i] = (CNT_W'(i) > cnt_q) ? '0 : slot_d[i];
        end
        cnt_d   = '0;
        start_d = 1'b1;
        short_d = (cnt_q != LAST_SLOT);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
    // A start and a returned result in the same cycle cancel out
    case ({start_q, adder_valid})
      2'b10: pend_d = pend_q + PEND_W'(1);
      2'b01: begin
        if (pend_q == '0) begin
          ovf_d = 1'b1;
        end else begin
          pend_d = pend_q - PEND_W'(1);
        end
      end
      default: pend_d = pend_q;
    endcase
  end

  // State registers with synchronous reset; a partial window is simply dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      start_q <= 1'b0;
      short_q <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      start_q <= start_d;
      short_q <= short_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_pack
    assign input_numbers[g*bitsize +: bitsize] = slot_q[g];
  end

  assign start_adder  = start_q;
  assign short_window = short_q;
  assign overflow_err = ovf_q;
  assign pending      = pend_q;
  assign idle         = (cnt_q == '0) && (pend_q == '0);

endmodule

// File: tb/tb_adder_operand_packer.sv
// Randomized scoreboard bench for adder_operand_packer: a window-level model queues the
// expected bus per start pulse; a monitor pops and compares, and checks status each cycle.
module tb_adder_operand_packer;
  localparam int W  = 14;
  localparam int N  = 27;
  localparam int MP = 8;
  localparam int PW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [W-1:0]     in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [N*W-1:0]   input_numbers;
  logic             start_adder;
  logic             adder_valid;
  logic [PW-1:0]    pending;
  logic             idle;
  logic             short_window;
  logic             overflow_err;

  logic             av_force = 1'b0;
  logic [5:0]       tree_pipe = '0;
  bit               tree_en = 1'b0;
  bit               mon_en = 1'b0;
  int               n_vec = 0;
  int               n_err = 0;
  int               n_start = 0;

  assign adder_valid = tree_pipe[5] | av_force;

  adder_operand_packer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .input_numbers(input_numbers), .start_adder(start_adder),
    .adder_valid(adder_valid), .pending(pending), .idle(idle),
    .short_window(short_window), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] bus;
    bit             short_w;
    int             sum;
  } win_t;
  win_t exp_q[$];

  // Window-level reference state
  int         m_cnt = 0;
  int         m_pend = 0;
  bit         m_start = 1'b0;
  bit         m_ovf = 1'b0;
  int         m_sum = 0;
  logic [W-1:0] m_win [N];

  function automatic void chk(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int bus_sum(logic [N*W-1:0] b);
    int s = 0;
    for (int i = 0; i < N; i++) s += $signed(b[i*W +: W]);
    return s;
  endfunction

  task automatic model_step();
    bit   rdy;
    win_t w;
    if (rst) begin
      m_cnt = 0; m_pend = 0; m_start = 1'b0; m_ovf = 1'b0; m_sum = 0;
    end else begin
      rdy = (m_pend < MP);
      if (m_start && !adder_valid) m_pend++;
      else if (!m_start && adder_valid) begin
        if (m_pend == 0) m_ovf = 1'b1;
        else m_pend--;
      end
      m_start = 1'b0;
      if (in_valid && rdy) begin
        m_win[m_cnt] = in_data;
        m_sum += $signed(in_data);
        if (in_last || m_cnt == N-1) begin
          w.bus = '0;
          for (int i = 0; i <= m_cnt; i++) w.bus[i*W +: W] = m_win[i];
          w.short_w = (m_cnt < N-1);
          w.sum = m_sum;
          exp_q.push_back(w);
          m_cnt = 0; m_sum = 0; m_start = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Emulated adder tree: result returns a fixed number of cycles after each start
  initial forever begin
    @(negedge clk);
    if (rst) tree_pipe = '0;
    else tree_pipe = {tree_pipe[4:0], start_adder & tree_en};
  end

  // Monitor / scoreboard
  initial begin : monitor
    win_t w;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("start_adder", start_adder, m_start);
        chk("pending", pending, m_pend);
        chk("in_ready", in_ready, (m_pend < MP));
        chk("overflow_err", overflow_err, m_ovf);
        chk("idle", idle, (m_cnt == 0 && m_pend == 0));
        if (start_adder) begin
          n_start++;
          if (exp_q.size() == 0) begin
            chk("unexpected_start", 1, 0);
          end else begin
            w = exp_q.pop_front();
            n_vec++;
            if (input_numbers !== w.bus) begin
              n_err++;
              $display("FAIL window_bus: got %h expected %h", input_numbers, w.bus);
            end
            chk("short_window", short_window, w.short_w);
            chk("window_sum", bus_sum(input_numbers), w.sum);
          end
        end else begin
          chk("short_without_start", short_window, 0);
        end
      end
    end
  end

  task automatic put(input logic [W-1:0] d, input bit last);
    bit ok;
    int budget = 300;
    in_valid = 1'b1; in_data = d; in_last = last;
    ok = in_ready;
    @(negedge clk);
    while (!ok && budget > 0) begin
      ok = in_ready;
      @(negedge clk);
      budget--;
    end
    if (!ok) chk("put_timeout", 0, 1);
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int budget = 500;
    gap(1);
    while (!(idle && exp_q.size() == 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("drain_timeout", 0, 1);
  endtask

  task automatic pulse_av(input int n);
    in_valid = 1'b0;
    av_force = 1'b1;
    repeat (n) @(negedge clk);
    av_force = 1'b0;
  endtask

  initial begin : stim
    int st0;
    int len;
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    n_vec++;
    if (input_numbers !== '0) begin
      n_err++;
      $display("FAIL reset_bus: got %h expected 0", input_numbers);
    end
    rst = 1'b0;
    tree_en = 1'b1;

    // 1: 1..27 with in_last on the 27th (full, not short)
    for (int i = 1; i <= N; i++) put(W'(i), i == N);
    drain();
    // 2: nine words of -1, short window
    for (int i = 1; i <= 9; i++) put({W{1'b1}}, i == 9);
    drain();
    // 3: 54 words back to back, no in_last
    for (int i = 0; i < 2*N; i++) put(W'($urandom), 1'b0);
    drain();
    // Random windows of varied length with random gaps
    for (int k = 0; k < 25; k++) begin
      len = $urandom_range(1, N);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
        put(W'($urandom), (i == len-1) ? ((len < N) ? 1'b1 : 1'($urandom)) : 1'b0);
      end
    end
    drain();

    // 4: no results returned, 8 full windows -> stalled
    tree_en = 1'b0;
    for (int i = 0; i < 8*N; i++) put(W'($urandom), 1'b0);
    gap(2);
    chk("t4_pending_full", pending, 8);
    chk("t4_ready_low", in_ready, 0);
    pulse_av(1);
    chk("t4_pending_after_one", pending, 7);
    chk("t4_ready_back", in_ready, 1);
    pulse_av(7);
    drain();

    // 5: reset drops a partial window
    for (int i = 0; i < 10; i++) put(W'($urandom), 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    st0 = n_start;
    for (int i = 0; i < N; i++) put(W'($urandom), i == N-1);
    gap(2);
    chk("t5_one_start", n_start - st0, 1);
    chk("t5_pending", pending, 1);
    pulse_av(1);
    drain();

    // 6: stray result sets sticky overflow; start + result together hold pending
    pulse_av(1);
    gap(1);
    chk("t6_overflow_set", overflow_err, 1);
    for (int i = 0; i < 3*N; i++) put(W'($urandom), 1'b0);
    gap(2);
    chk("t6_pending3", pending, 3);
    for (int i = 0; i < N; i++) put(W'($urandom), 1'b0);
    av_force = 1'b1;
    in_valid = 1'b0;
    chk("t6_start_now", start_adder, 1);
    @(negedge clk);
    av_force = 1'b0;
    chk("t6_pending_held", pending, 3);
    pulse_av(3);
    drain();
    chk("t6_overflow_sticky", overflow_err, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
